// File: rtl/sr_mdu_pkg.sv
// rtl/sr_mdu_pkg.sv - shared constants, state encoding and operand-sign helpers for sr_mdu
package sr_mdu_pkg;

  localparam logic [6:0] RVF7_MULDIV = 7'b0000001;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
  endfunction

endpackage

// File: rtl/sr_mdu_abs.sv
// rtl/sr_mdu_abs.sv - conditional two's-complement negate
module sr_mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(WIDTH-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/sr_mdu.sv
// rtl/sr_mdu.sv - iterative radix-2 RV32M multiply/divide unit with start/done handshake
module sr_mdu
  import sr_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             kill,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_t         r_state;
  logic               r_ready;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic               r_is_div;
  logic               r_hi;
  logic               r_neg;

  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_div0;
  logic               w_ovf;
  logic               w_fast;
  logic [WIDTH-1:0]   w_fast_res;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_fix_in;
  logic [2*WIDTH-1:0] w_fix_out;
  logic [WIDTH-1:0]   w_fix_res;

  assign w_sa = op_signed_a(op) & srcA[WIDTH-1];
  assign w_sb = op_signed_b(op) & srcB[WIDTH-1];

  sr_mdu_abs #(.WIDTH(WIDTH)) u_abs_a (.i_val(srcA), .i_neg(w_sa), .o_val(w_mag_a));
  sr_mdu_abs #(.WIDTH(WIDTH)) u_abs_b (.i_val(srcB), .i_neg(w_sb), .o_val(w_mag_b));

  // Divide corner cases bypass the datapath entirely and finish in one cycle.
  assign w_div0 = op[2] && (srcB == '0);
  assign w_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) &&
                  (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (srcB == '1);
  assign w_fast = w_div0 || w_ovf;
  assign w_fast_res = w_div0 ? (op[1] ? srcA : '1) : (op[1] ? '0 : srcA);

  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Upper half holds the partial remainder, lower half shifts dividend out and quotient in.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_qbit     = (w_rem_sh >= {1'b0, r_opnd});
  assign w_diff     = w_rem_sh[WIDTH-1:0] - r_opnd;
  assign w_div_next = {(w_qbit ? w_diff : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};

  assign w_fix_in = r_is_div ? {{WIDTH{1'b0}}, (r_hi ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0])}
                             : r_acc;

  sr_mdu_abs #(.WIDTH(2*WIDTH)) u_fix (.i_val(w_fix_in), .i_neg(r_neg), .o_val(w_fix_out));

  assign w_fix_res = (!r_is_div && r_hi) ? w_fix_out[2*WIDTH-1:WIDTH] : w_fix_out[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_hi     <= 1'b0;
      r_neg    <= 1'b0;
    end else if (kill) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          if (start) begin
            r_cnt    <= CW'(WIDTH-1);
            r_is_div <= op[2];
            r_hi     <= op[2] ? op[1] : (op[1:0] != 2'b00);
            r_neg    <= (op[2] && op[1]) ? w_sa : (w_sa ^ w_sb);
            r_acc    <= {{WIDTH{1'b0}}, (op[2] ? w_mag_a : w_mag_b)};
            r_opnd   <= op[2] ? w_mag_b : w_mag_a;
            if (w_fast) begin
              r_result <= w_fast_res;
              r_done   <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
              r_ready <= 1'b0;
            end
          end
        end
        ST_CALC: begin
          r_acc <= r_is_div ? w_div_next : w_mul_next;
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          r_result <= w_fix_res;
          r_done   <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = r_ready;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_sr_mdu.sv
// tb/tb_sr_mdu.sv - self-checking bench for sr_mdu (WIDTH=32)
module tb_sr_mdu;
  import sr_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        ready;
  logic        done;
  logic [31:0] result;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  sr_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .op(op),
    .srcA(srcA), .srcB(srcB), .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M reference semantics computed with wide integer arithmetic
  function automatic logic [31:0] mdl_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      MDU_MUL:    begin p = sa * sb; return p[31:0];  end
      MDU_MULH:   begin p = sa * sb; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub; return p[63:32]; end
      MDU_MULHU:  begin p = ua * ub; return p[63:32]; end
      MDU_DIV:    begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      MDU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      MDU_REM:    begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default:    return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit mdl_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Cycle-level model: cycle index, pending op with its due cycle, visible result
  int          cyc       = 0;
  bit          m_pend    = 1'b0;
  int          m_done_at = 0;
  logic [31:0] m_exp     = '0;
  logic [31:0] m_res     = '0;

  always @(posedge clk or posedge rst) begin
    bit r;
    if (rst) begin
      m_pend = 1'b0;
      m_res  = '0;
    end else begin
      r = !(m_pend && cyc < m_done_at);
      cyc = cyc + 1;
      if (kill) begin
        m_pend = 1'b0;
      end else if (start && r) begin
        m_pend    = 1'b1;
        m_exp     = mdl_result(op, srcA, srcB);
        m_done_at = cyc + (mdl_fast(op, srcA, srcB) ? 0 : 33);
      end
      if (m_pend && cyc == m_done_at) m_res = m_exp;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'b0, ready}, {31'b0, !(m_pend && cyc < m_done_at)});
      chk("done", {31'b0, done}, {31'b0, (m_pend && cyc == m_done_at)});
      chk("result", result, m_res);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp, input int exp_lat, input int poke);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    @(posedge clk);
    while (!seen && k < 100) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        start = 1'b0;
        op    = 3'($urandom);
        srcA  = $urandom;
        srcB  = $urandom;
      end
      if (poke != 0 && k == poke) issue(MDU_DIVU, 32'd1, 32'd0);
      if (poke != 0 && k == poke + 1) start = 1'b0;
      if (done) seen = 1'b1;
    end
    chk({name, "_seen"}, {31'b0, seen}, 32'd1);
    chk({name, "_lat"}, 32'(k), 32'(exp_lat));
    chk({name, "_res"}, result, exp);
  endtask

  task automatic count_done(input string name, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk(name, 32'(cnt), 32'd0);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    kill  = 1'b0;
    op    = '0;
    srcA  = '0;
    srcB  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_ready", {31'b0, ready}, 32'd1);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk_en = 1'b1;

    @(negedge clk); issue(MDU_MUL,    32'd7,          32'hFFFF_FFFD); wait_done("mul",    32'hFFFF_FFEB, 34, 0);
    @(negedge clk); issue(MDU_MULH,   32'h8000_0000,  32'h8000_0000); wait_done("mulh",   32'h4000_0000, 34, 0);
    @(negedge clk); issue(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF); wait_done("mulhu",  32'hFFFF_FFFE, 34, 0);
    @(negedge clk); issue(MDU_MULHSU, 32'hFFFF_FFFF,  32'd2);         wait_done("mulhsu", 32'hFFFF_FFFF, 34, 0);
    @(negedge clk); issue(MDU_DIV,    32'hFFFF_FFF9,  32'd2);         wait_done("div",    32'hFFFF_FFFD, 34, 0);
    @(negedge clk); issue(MDU_REM,    32'hFFFF_FFF9,  32'd2);         wait_done("rem",    32'hFFFF_FFFF, 34, 0);
    @(negedge clk); issue(MDU_DIVU,   32'd100,        32'd7);         wait_done("divu",   32'd14,        34, 0);

    // Kill in cycle N+10: idle at N+11 and the previous result survives
    @(negedge clk); issue(MDU_MUL, 32'd3, 32'd3);
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 10) kill = 1'b1;
    end
    @(negedge clk);
    kill = 1'b0;
    chk("kill_ready", {31'b0, ready}, 32'd1);
    chk("kill_done", {31'b0, done}, 32'd0);
    chk("kill_result", result, 32'd14);
    count_done("kill_no_done", 40);

    @(negedge clk); issue(MDU_DIVU, 32'd5,         32'd0);         wait_done("divu_z", 32'hFFFF_FFFF, 1, 0);
    @(negedge clk); issue(MDU_REMU, 32'd5,         32'd0);         wait_done("remu_z", 32'd5,         1, 0);
    @(negedge clk); issue(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ov", 32'h8000_0000, 1, 0);
    @(negedge clk); issue(MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF); wait_done("rem_ov", 32'd0,         1, 0);

    // start together with kill in IDLE is dropped
    @(negedge clk); issue(MDU_MUL, 32'd3, 32'd3); kill = 1'b1;
    @(negedge clk); start = 1'b0; kill = 1'b0;
    chk("sk_ready", {31'b0, ready}, 32'd1);
    count_done("sk_no_done", 40);
    chk("sk_result", result, 32'd0);

    // Back-to-back: second start issued in the DONE cycle; a third start pulsed mid-CALC is ignored
    @(negedge clk); issue(MDU_MUL, 32'd6, 32'd7); wait_done("b2b_1", 32'd42, 34, 0);
    issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE);          wait_done("b2b_2", 32'hFFFF_FFFD, 34, 5);
    issue(MDU_REM, 32'd7, 32'hFFFF_FFFE);          wait_done("b2b_3", 32'd1, 34, 12);

    // Asynchronous reset mid-CALC
    @(negedge clk); issue(MDU_MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", {31'b0, ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    count_done("rst_no_done", 40);

    for (int i = 0; i < 8; i++) begin
      ro = 3'(i);
      ra = $urandom;
      rb = (i == 7) ? 32'd0 : $urandom;
      @(negedge clk); issue(ro, ra, rb);
      wait_done("rnd", mdl_result(ro, ra, rb), mdl_fast(ro, ra, rb) ? 1 : 34, 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
